// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM state type, response bundle, and store byte-lane helpers.
package dmem_responder_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        valid;
    logic [6:0]  pd;
    logic [4:0]  rob;
    logic [31:0] data;
    logic        err;
  } dmem_resp_t;

  // Byte enables for a store; misaligned sh/sw and unknown encodings write nothing.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
      F3_SW:   be = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low store bytes onto every lane so the enables pick the right one.
  function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] lane;
    case (f3)
      F3_SB:   lane = {4{d[7:0]}};
      F3_SH:   lane = {2{d[15:0]}};
      default: lane = d;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extract.sv
// Combinational load formatter: selects byte/halfword/word from a RAM word,
// applies sign or zero extension, and flags misaligned lh/lw (data forced to 0).
module load_extract
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Extract and extend according to the access width and signedness
  always_comb begin
    data = 32'h0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        if (off[0]) err = 1'b1;
        else        data = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off[0]) err = 1'b1;
        else        data = {16'h0, half_sel};
      end
      F3_LW: begin
        if (off != 2'b00) err = 1'b1;
        else              data = word;
      end
      default: begin
        data = 32'h0;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: word-addressed data RAM with byte-enabled store
// write-back, fixed-latency load pipeline with a single-cycle response pulse,
// and mispredict squash of in-flight loads younger than the flushing branch.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LOAD_LAT  = 2,
  parameter int ROB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [6:0]  ld_pd,
  input  logic [4:0]  ld_rob,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  input  logic [4:0]  rob_head,
  input  logic        flush,
  input  logic [4:0]  flush_tag,
  output logic        resp_valid,
  output logic [6:0]  resp_pd,
  output logic [4:0]  resp_rob,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam int AGE_W = $clog2(ROB_DEPTH);

  // RAM and its registered read port
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  // Same-cycle store bytes captured alongside the read so the held load sees them
  logic [3:0]  byp_be_q;
  logic [31:0] byp_data_q;

  // Held load request
  dmem_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [2:0]       f3_q;
  logic [6:0]       pd_q;
  logic [4:0]       rob_q;

  logic [IDX_W-1:0] st_idx;
  logic [IDX_W-1:0] ld_idx;
  logic [3:0]       st_be;
  logic [31:0]      st_lane;
  logic [AGE_W-1:0] age_ld;
  logic [AGE_W-1:0] age_fl;
  logic             kill;
  logic             ld_accept;
  logic             rd_en;
  logic [31:0]      word_merged;
  logic [31:0]      ext_data;
  logic             ext_err;
  dmem_resp_t       resp;
  logic             unused_bits;

  assign st_idx  = st_addr[2 +: IDX_W];
  assign ld_idx  = addr_q[2 +: IDX_W];
  assign st_be   = st_valid ? store_be(st_funct3, st_addr[1:0]) : 4'b0000;
  assign st_lane = store_lane(st_funct3, st_data);

  // Ages relative to the ROB head; strictly younger than the branch is killed
  assign age_ld = AGE_W'(rob_q - rob_head);
  assign age_fl = AGE_W'(flush_tag - rob_head);
  assign kill   = flush && (state_q != IDLE) && (age_ld > age_fl);

  assign ld_req_ready = !reset && (state_q == IDLE) && !st_valid && !flush;
  assign ld_accept    = ld_req_valid && ld_req_ready;
  assign st_ready     = 1'b1;
  assign rd_en        = (state_q == WAIT) && (cnt_q == CNT_W'(1)) && !kill;

  // RAM: byte-enabled write at any time, registered read in the last WAIT cycle
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (st_be[b]) mem_q[st_idx][b*8 +: 8] <= st_lane[b*8 +: 8];
    end
    if (rd_en) rdata_q <= mem_q[ld_idx];
  end

  // Capture any store landing on the word being read in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_be_q   <= 4'b0000;
      byp_data_q <= 32'h0;
    end else if (rd_en) begin
      byp_be_q   <= (st_idx == ld_idx) ? st_be : 4'b0000;
      byp_data_q <= st_lane;
    end
  end

  // Per-lane merge of RAM read data with the captured store bytes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign word_merged[gi*8 +: 8] = byp_be_q[gi] ? byp_data_q[gi*8 +: 8] : rdata_q[gi*8 +: 8];
    end
  endgenerate

  load_extract u_extract (
    .word   (word_merged),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ext_data),
    .err    (ext_err)
  );

  // Load FSM: accept, count down the latency, present one response, return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      pd_q    <= 7'h0;
      rob_q   <= 5'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_accept) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(LOAD_LAT - 1);
            addr_q  <= ld_addr;
            f3_q    <= ld_funct3;
            pd_q    <= ld_pd;
            rob_q   <= ld_rob;
          end
        end
        WAIT: begin
          if (kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response bundle, zeroed whenever there is no valid (or a squashed) response
  always_comb begin
    resp = '0;
    if ((state_q == RESP) && !kill) begin
      resp.valid = 1'b1;
      resp.pd    = pd_q;
      resp.rob   = rob_q;
      resp.data  = ext_data;
      resp.err   = ext_err;
    end
  end

  assign resp_valid = resp.valid;
  assign resp_pd    = resp.pd;
  assign resp_rob   = resp.rob;
  assign resp_data  = resp.data;
  assign resp_err   = resp.err;

  // Upper address bits alias onto the RAM and are intentionally ignored
  assign unused_bits = ^{st_addr[31:2+IDX_W], addr_q[31:2+IDX_W]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores, loads of every width, bypass of a
// store into a held load, store/load priority, flush squash and mid-load reset.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [31:0] ld_addr = 32'h0;
  logic [2:0]  ld_funct3 = 3'b000;
  logic [6:0]  ld_pd = 7'h0;
  logic [4:0]  ld_rob = 5'h0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [2:0]  st_funct3 = 3'b000;
  logic [4:0]  rob_head = 5'h0;
  logic        flush = 1'b0;
  logic [4:0]  flush_tag = 5'h0;
  logic        resp_valid;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;
  logic [31:0] resp_data;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_addr      (ld_addr),
    .ld_funct3    (ld_funct3),
    .ld_pd        (ld_pd),
    .ld_rob       (ld_rob),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_funct3    (st_funct3),
    .rob_head     (rob_head),
    .flush        (flush),
    .flush_tag    (flush_tag),
    .resp_valid   (resp_valid),
    .resp_pd      (resp_pd),
    .resp_rob     (resp_rob),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    #1 chk("st_ready", 32'(st_ready), 32'd1);
    cyc();
    st_valid = 1'b0;
    $display("store f3=%0d addr=0x%08h data=0x%08h", f3, a, d);
  endtask

  // Full load transaction: accept at T, nothing at T+1, response at T+2
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                      input logic [6:0] pd, input logic [4:0] rob,
                      input logic [31:0] exp_d, input logic exp_e);
    ld_req_valid = 1'b1; ld_addr = a; ld_funct3 = f3; ld_pd = pd; ld_rob = rob;
    #1 chk({tag, ".ready"}, 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0;
    #1 chk({tag, ".early"}, 32'(resp_valid), 32'd0);
    cyc();
    #1;
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".data"},  resp_data,        exp_d);
    chk({tag, ".pd"},    32'(resp_pd),     32'(pd));
    chk({tag, ".rob"},   32'(resp_rob),    32'(rob));
    chk({tag, ".err"},   32'(resp_err),    32'(exp_e));
    cyc();
    $display("load %s f3=%0d addr=0x%08h expect data=0x%08h err=%0b", tag, f3, a, exp_d, exp_e);
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.ld_ready",   32'(ld_req_ready), 32'd0);
    chk("rst.st_ready",   32'(st_ready), 32'd1);
    chk("rst.resp_data",  resp_data, 32'd0);
    cyc();
    reset = 1'b0;
    #1 chk("idle.ld_ready", 32'(ld_req_ready), 32'd1);

    // Word store then loads of every width
    store(32'h10, 32'hDEADBEEF, F3_SW);
    load("lw10",  32'h10, F3_LW,  7'd5, 5'd3, 32'hDEADBEEF, 1'b0);
    load("lb13",  32'h13, F3_LB,  7'd6, 5'd4, 32'hFFFFFFDE, 1'b0);
    load("lbu13", 32'h13, F3_LBU, 7'd7, 5'd5, 32'h000000DE, 1'b0);
    load("lh12",  32'h12, F3_LH,  7'd8, 5'd6, 32'hFFFFDEAD, 1'b0);
    load("lhu10", 32'h10, F3_LHU, 7'd9, 5'd7, 32'h0000BEEF, 1'b0);

    // Store to the held word during WAIT is seen by the load
    ld_req_valid = 1'b1; ld_addr = 32'h20; ld_funct3 = F3_LW; ld_pd = 7'd10; ld_rob = 5'd8;
    #1 chk("byp.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h12345678; st_funct3 = F3_SW;
    #1 chk("byp.early", 32'(resp_valid), 32'd0);
    cyc();
    st_valid = 1'b0;
    #1 chk("byp.valid", 32'(resp_valid), 32'd1);
    chk("byp.data", resp_data, 32'h12345678);
    cyc();
    $display("load byp addr=0x00000020 with store in WAIT");

    // Misaligned loads
    load("lw22", 32'h22, F3_LW, 7'd11, 5'd9,  32'h0, 1'b1);
    load("lh11", 32'h11, F3_LH, 7'd12, 5'd10, 32'h0, 1'b1);

    // Same-cycle load and store: store wins, load accepted next cycle
    ld_req_valid = 1'b1; ld_addr = 32'h30; ld_funct3 = F3_LW; ld_pd = 7'd13; ld_rob = 5'd11;
    st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hCAFEF00D; st_funct3 = F3_SW;
    #1 chk("prio.blocked", 32'(ld_req_ready), 32'd0);
    cyc();
    st_valid = 1'b0;
    #1 chk("prio.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0;
    #1 chk("prio.early", 32'(resp_valid), 32'd0);
    cyc();
    #1 chk("prio.valid", 32'(resp_valid), 32'd1);
    chk("prio.data", resp_data, 32'hCAFEF00D);
    cyc();
    $display("load prio addr=0x00000030 after same-cycle store");

    // Byte/half stores, suppressed misaligned store, address aliasing
    store(32'h40, 32'h11223344, F3_SW);
    store(32'h41, 32'h000000AB, F3_SB);
    store(32'h42, 32'h0000BEEF, F3_SH);
    store(32'h41, 32'hFFFFFFFF, F3_SW);
    store(32'h43, 32'h0000FFFF, F3_SH);
    load("lw40",  32'h40,  F3_LW, 7'd14, 5'd12, 32'hBEEFAB44, 1'b0);
    load("lb41",  32'h41,  F3_LB, 7'd15, 5'd13, 32'hFFFFFFAB, 1'b0);
    load("alias", 32'h440, F3_LW, 7'd16, 5'd14, 32'hBEEFAB44, 1'b0);

    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    #1 chk("flush.idle_ready", 32'(ld_req_ready), 32'd0);
    cyc();
    flush = 1'b0;

    // Younger load squashed during WAIT (head 14: load age 3, branch age 1)
    rob_head = 5'd14;
    ld_req_valid = 1'b1; ld_addr = 32'h10; ld_funct3 = F3_LW; ld_pd = 7'd20; ld_rob = 5'd1;
    #1 chk("kill.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0; flush = 1'b1; flush_tag = 5'd15;
    #1 chk("kill.early", 32'(resp_valid), 32'd0);
    cyc();
    flush = 1'b0;
    #1 chk("kill.valid", 32'(resp_valid), 32'd0);
    chk("kill.pd", 32'(resp_pd), 32'd0);
    cyc();
    #1 chk("kill.idle", 32'(ld_req_ready), 32'd1);
    $display("load kill rob=1 head=14 flush_tag=15 squashed");

    // Older load survives (branch age 4)
    ld_req_valid = 1'b1;
    #1 chk("keep.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0; flush = 1'b1; flush_tag = 5'd2;
    #1;
    cyc();
    flush = 1'b0;
    #1 chk("keep.valid", 32'(resp_valid), 32'd1);
    chk("keep.data", resp_data, 32'hDEADBEEF);
    chk("keep.rob", 32'(resp_rob), 32'd1);
    cyc();
    $display("load keep rob=1 head=14 flush_tag=2 delivered");

    // Flush arriving in the RESP cycle suppresses the pulse
    ld_req_valid = 1'b1;
    #1 chk("respkill.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0;
    cyc();
    flush = 1'b1; flush_tag = 5'd15;
    #1 chk("respkill.valid", 32'(resp_valid), 32'd0);
    chk("respkill.data", resp_data, 32'd0);
    cyc();
    flush = 1'b0; rob_head = 5'd0;
    $display("load respkill rob=1 flushed in RESP cycle");

    // Reset during WAIT aborts at once; RAM contents survive
    ld_req_valid = 1'b1; ld_addr = 32'h10; ld_funct3 = F3_LW; ld_pd = 7'd21; ld_rob = 5'd2;
    #1 chk("rstwait.ready", 32'(ld_req_ready), 32'd1);
    cyc();
    ld_req_valid = 1'b0; reset = 1'b1;
    #1 chk("rstwait.ld_ready", 32'(ld_req_ready), 32'd0);
    chk("rstwait.valid0", 32'(resp_valid), 32'd0);
    cyc();
    #1 chk("rstwait.valid1", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    cyc();
    #1 chk("rstwait.valid2", 32'(resp_valid), 32'd0);
    $display("reset during WAIT, no response");
    load("after_rst", 32'h10, F3_LW, 7'd22, 5'd3, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
